// File: rtl/alu_arbiter_pkg.sv
// alu_arbiter_pkg: ALU command encodings and arbiter FSM state encodings shared by the ALU slice
package alu_arbiter_pkg;
    typedef enum logic [2:0] {
        CMD_ADD  = 3'd0,
        CMD_SUB  = 3'd1,
        CMD_XOR  = 3'd2,
        CMD_SLT  = 3'd3,
        CMD_AND  = 3'd4,
        CMD_NAND = 3'd5,
        CMD_OR   = 3'd6,
        CMD_NOR  = 3'd7
    } alu_cmd_e;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETTLE = 2'd1;
    localparam logic [1:0] RESP   = 2'd2;
endpackage

// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: requester, response and ALU-side signals of the shared ALU arbiter
interface alu_arbiter_if #(parameter int WIDTH = 32);
    logic             req0_valid, req0_ready;
    logic [2:0]       req0_cmd;
    logic [WIDTH-1:0] req0_a, req0_b;
    logic             req1_valid, req1_ready;
    logic [2:0]       req1_cmd;
    logic [WIDTH-1:0] req1_a, req1_b;
    logic             rsp_valid, rsp_ready, rsp_id;
    logic [WIDTH-1:0] rsp_result;
    logic             rsp_carryout, rsp_overflow, rsp_zero;
    logic [2:0]       alu_cmd;
    logic [WIDTH-1:0] alu_a, alu_b, alu_out;
    logic             alu_carryout, alu_overflow, alu_zero;
    logic             busy;

    modport slave (
        input  req0_valid, req0_cmd, req0_a, req0_b,
        input  req1_valid, req1_cmd, req1_a, req1_b,
        input  rsp_ready, alu_out, alu_carryout, alu_overflow, alu_zero,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_id, rsp_result, rsp_carryout, rsp_overflow, rsp_zero,
        output alu_cmd, alu_a, alu_b, busy
    );

    modport master (
        output req0_valid, req0_cmd, req0_a, req0_b,
        output req1_valid, req1_cmd, req1_a, req1_b,
        output rsp_ready, alu_out, alu_carryout, alu_overflow, alu_zero,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_id, rsp_result, rsp_carryout, rsp_overflow, rsp_zero,
        input  alu_cmd, alu_a, alu_b, busy
    );
endinterface

// File: rtl/alu_arbiter_rr_arbiter2.sv
// rr_arbiter2: two-way round-robin grant that favours the requester not served last
module rr_arbiter2 (
    input  logic valid0,
    input  logic valid1,
    input  logic last_grant,
    output logic grant0,
    output logic grant1
);
    assign grant0 = valid0 & (~valid1 | last_grant);
    assign grant1 = valid1 & (~valid0 | ~last_grant);
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sequencer holding operands on the shared gate-level ALU until its outputs settle
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int WIDTH         = 32,
    parameter int SETTLE_CYCLES = 4
) (
    input logic          clk,
    input logic          rst_n,
    alu_arbiter_if.slave bus
);
    localparam int CW = SETTLE_CYCLES > 1 ? $clog2(SETTLE_CYCLES) : 1;

    if (SETTLE_CYCLES < 1) begin : g_bad_settle
        $error("SETTLE_CYCLES must be at least 1");
    end

    logic [1:0]       state;
    logic [CW-1:0]    cnt;
    logic             id, last_grant, grant0, grant1, accept;
    logic [2:0]       sel_cmd;
    logic [WIDTH-1:0] sel_a, sel_b;

    rr_arbiter2 u_rr (
        .valid0     (bus.req0_valid),
        .valid1     (bus.req1_valid),
        .last_grant (last_grant),
        .grant0     (grant0),
        .grant1     (grant1)
    );

    // Ready is withheld during reset so a request held across reset is never taken
    assign bus.req0_ready = rst_n && state == IDLE && grant0;
    assign bus.req1_ready = rst_n && state == IDLE && grant1;
    assign bus.busy       = state != IDLE;
    assign accept         = bus.req0_ready | bus.req1_ready;

    always_comb begin
        sel_cmd = grant1 ? bus.req1_cmd : bus.req0_cmd;
        sel_a   = grant1 ? bus.req1_a : bus.req0_a;
        sel_b   = grant1 ? bus.req1_b : bus.req0_b;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state            <= IDLE;
            cnt              <= '0;
            id               <= 1'b0;
            last_grant       <= 1'b1;
            bus.alu_cmd      <= CMD_ADD;
            bus.alu_a        <= '0;
            bus.alu_b        <= '0;
            bus.rsp_valid    <= 1'b0;
            bus.rsp_id       <= 1'b0;
            bus.rsp_result   <= '0;
            bus.rsp_carryout <= 1'b0;
            bus.rsp_overflow <= 1'b0;
            bus.rsp_zero     <= 1'b0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    bus.alu_cmd <= sel_cmd;
                    bus.alu_a   <= sel_a;
                    bus.alu_b   <= sel_b;
                    id          <= grant1;
                    cnt         <= CW'(SETTLE_CYCLES - 1);
                    state       <= SETTLE;
                end
                SETTLE: if (cnt == '0) begin
                    bus.rsp_valid    <= 1'b1;
                    bus.rsp_id       <= id;
                    bus.rsp_result   <= bus.alu_out;
                    bus.rsp_carryout <= bus.alu_carryout;
                    bus.rsp_overflow <= bus.alu_overflow;
                    bus.rsp_zero     <= bus.alu_zero;
                    state            <= RESP;
                end else begin
                    cnt <= cnt - 1'b1;
                end
                RESP: if (bus.rsp_ready) begin
                    last_grant    <= bus.rsp_id;
                    bus.rsp_valid <= 1'b0;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed and randomized checks of alu_arbiter against a transaction-level model
module tb_alu_arbiter;
    import alu_arbiter_pkg::*;

    localparam int W = 32;
    localparam int S = 4;

    typedef struct packed {
        logic [W-1:0] out;
        logic         co;
        logic         ov;
        logic         z;
    } alu_res_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    alu_arbiter_if #(.WIDTH(W)) bus ();

    alu_arbiter #(.WIDTH(W), .SETTLE_CYCLES(S)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    function automatic alu_res_t alu_f(input logic [2:0] cmd, input logic [W-1:0] a, input logic [W-1:0] b);
        alu_res_t   r;
        logic [W:0] s;
        r = '0;
        s = '0;
        case (alu_cmd_e'(cmd))
            CMD_ADD: begin
                s    = {1'b0, a} + {1'b0, b};
                r.out = s[W-1:0];
                r.co  = s[W];
                r.ov  = (a[W-1] == b[W-1]) && (r.out[W-1] != a[W-1]);
            end
            CMD_SUB: begin
                s    = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
                r.out = s[W-1:0];
                r.co  = s[W];
                r.ov  = (a[W-1] != b[W-1]) && (r.out[W-1] != a[W-1]);
            end
            CMD_XOR:  r.out = a ^ b;
            CMD_SLT:  r.out = W'($signed(a) < $signed(b));
            CMD_AND:  r.out = a & b;
            CMD_NAND: r.out = ~(a & b);
            CMD_OR:   r.out = a | b;
            CMD_NOR:  r.out = ~(a | b);
        endcase
        r.z = r.out == '0;
        return r;
    endfunction

    // ALU outputs read as the inverse of the true result until the inputs have been stable long enough
    logic [2*W+2:0] alu_prev;
    int             alu_age = 0;
    alu_res_t       alu_now;

    always @(negedge clk) begin
        if ({bus.alu_cmd, bus.alu_a, bus.alu_b} !== alu_prev) begin
            alu_prev = {bus.alu_cmd, bus.alu_a, bus.alu_b};
            alu_age  = 0;
        end else begin
            alu_age++;
        end
    end

    always_comb begin
        alu_now = alu_f(bus.alu_cmd, bus.alu_a, bus.alu_b);
        if (alu_age < S - 1) alu_now = ~alu_now;
    end

    assign bus.alu_out      = alu_now.out;
    assign bus.alu_carryout = alu_now.co;
    assign bus.alu_overflow = alu_now.ov;
    assign bus.alu_zero     = alu_now.z;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    int edge_n = 0;
    always @(posedge clk) edge_n++;

    // Transaction model: one op in flight, response due S edges after acceptance, round-robin on ties
    logic         mon_en = 1'b0;
    logic         m_busy = 1'b0;
    logic         m_last = 1'b1;
    logic         m_id = 1'b0;
    int           m_acc = 0;
    logic [2:0]   m_cmd = '0;
    logic [W-1:0] m_a = '0, m_b = '0;
    int           n_rsp = 0;

    always @(negedge clk) begin
        logic     exp_rv, exp_r0, exp_r1;
        alu_res_t e;
        exp_rv = m_busy && edge_n >= m_acc + S;
        exp_r0 = rst_n && !m_busy && bus.req0_valid && (!bus.req1_valid || m_last);
        exp_r1 = rst_n && !m_busy && bus.req1_valid && (!bus.req0_valid || !m_last);
        if (mon_en) begin
            check("m_req0_ready", W'(bus.req0_ready), W'(exp_r0));
            check("m_req1_ready", W'(bus.req1_ready), W'(exp_r1));
            check("m_busy", W'(bus.busy), W'(m_busy));
            check("m_rsp_valid", W'(bus.rsp_valid), W'(exp_rv));
            if (m_busy) begin
                check("m_alu_cmd", W'(bus.alu_cmd), W'(m_cmd));
                check("m_alu_a", bus.alu_a, m_a);
                check("m_alu_b", bus.alu_b, m_b);
            end
            if (exp_rv) begin
                e = alu_f(m_cmd, m_a, m_b);
                check("m_rsp_id", W'(bus.rsp_id), W'(m_id));
                check("m_rsp_result", bus.rsp_result, e.out);
                check("m_rsp_carry", W'(bus.rsp_carryout), W'(e.co));
                check("m_rsp_ovf", W'(bus.rsp_overflow), W'(e.ov));
                check("m_rsp_zero", W'(bus.rsp_zero), W'(e.z));
            end
        end
        if (!rst_n) begin
            m_busy = 1'b0;
            m_last = 1'b1;
        end else if (exp_rv && bus.rsp_ready) begin
            m_busy = 1'b0;
            m_last = m_id;
            n_rsp++;
        end else if (exp_r0 || exp_r1) begin
            m_busy = 1'b1;
            m_id   = exp_r1;
            m_acc  = edge_n + 1;
            m_cmd  = exp_r1 ? bus.req1_cmd : bus.req0_cmd;
            m_a    = exp_r1 ? bus.req1_a : bus.req0_a;
            m_b    = exp_r1 ? bus.req1_b : bus.req0_b;
        end
    end

    task automatic wait_accept(output int who);
        who = -1;
        for (int i = 0; i < 40 && who < 0; i++) begin
            @(negedge clk);
            if (bus.req0_valid && bus.req0_ready) who = 0;
            else if (bus.req1_valid && bus.req1_ready) who = 1;
        end
        n_cmp++;
        assert (who >= 0) else begin
            n_err++;
            $error("FAIL accept_timeout: observed no grant, expected one within 40 clocks");
        end
    endtask

    task automatic wait_rsp(output int lat);
        lat = -1;
        for (int k = 1; k <= 40 && lat < 0; k++) begin
            @(negedge clk);
            if (bus.rsp_valid) lat = k - 1;
        end
        n_cmp++;
        assert (lat >= 0) else begin
            n_err++;
            $error("FAIL rsp_timeout: observed no rsp_valid, expected one within 40 clocks");
        end
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 4))
            0: return '0;
            1: return '1;
            2: return 32'h7FFF_FFFF;
            3: return 32'h8000_0000;
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int           who, lat, base;
        int           g [6];
        logic         rid [6];
        logic         rz [6];
        logic [W-1:0] res [6];
        logic [W-1:0] sr, sa, sb;
        logic         seen;
        bus.req0_valid = 1'b1;
        bus.req0_cmd   = CMD_ADD;
        bus.req0_a     = 5;
        bus.req0_b     = 7;
        bus.req1_valid = 1'b0;
        bus.req1_cmd   = CMD_ADD;
        bus.req1_a     = '0;
        bus.req1_b     = '0;
        bus.rsp_ready  = 1'b1;
        // Reset held for two edges with req0 valid
        @(posedge clk); #1 mon_en = 1'b1;
        @(negedge clk);
        check("rst_req0_ready", W'(bus.req0_ready), 0);
        check("rst_rsp_valid", W'(bus.rsp_valid), 0);
        check("rst_busy", W'(bus.busy), 0);
        check("rst_alu_cmd", W'(bus.alu_cmd), 0);
        check("rst_alu_a", bus.alu_a, 0);
        check("rst_alu_b", bus.alu_b, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        // Single ADD from requester 0
        wait_accept(who);
        check("t2_grant", who, 0);
        check("t2_busy_pre", W'(bus.busy), 0);
        @(posedge clk); #1 bus.req0_valid = 1'b0;
        wait_rsp(lat);
        check("t2_latency", lat, S);
        check("t2_result", bus.rsp_result, 12);
        check("t2_id", W'(bus.rsp_id), 0);
        check("t2_zero", W'(bus.rsp_zero), 0);
        check("t2_carry", W'(bus.rsp_carryout), 0);
        check("t2_ovf", W'(bus.rsp_overflow), 0);
        // Contention after a fresh reset: requester 0 wins the first tie, then strict alternation
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        bus.req0_valid = 1'b1; bus.req0_cmd = CMD_SUB; bus.req0_a = 3; bus.req0_b = 3;
        bus.req1_valid = 1'b1; bus.req1_cmd = CMD_SLT; bus.req1_a = 2; bus.req1_b = 5;
        for (int i = 0; i < 6; i++) begin
            wait_accept(g[i]);
            wait_rsp(lat);
            rid[i] = bus.rsp_id;
            rz[i]  = bus.rsp_zero;
            res[i] = bus.rsp_result;
        end
        @(posedge clk); #1 bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            check("t3_grant", g[i], i % 2);
            check("t3_rsp_id", W'(rid[i]), W'(i % 2));
        end
        check("t3_sub_result", res[0], 0);
        check("t3_sub_zero", W'(rz[0]), 1);
        check("t3_slt_result", res[1], 1);
        check("t3_slt_zero", W'(rz[1]), 0);
        // Backpressure: response held for 10 clocks while req0 waits
        bus.rsp_ready = 1'b0;
        bus.req1_valid = 1'b1; bus.req1_cmd = CMD_AND; bus.req1_a = W'($urandom); bus.req1_b = W'($urandom);
        wait_accept(who);
        check("t4_grant", who, 1);
        @(posedge clk); #1 bus.req1_valid = 1'b0;
        wait_rsp(lat);
        sr = bus.rsp_result; sa = bus.alu_a; sb = bus.alu_b;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (i == 0) begin
                bus.req0_valid = 1'b1; bus.req0_cmd = CMD_OR; bus.req0_a = W'($urandom); bus.req0_b = W'($urandom);
            end
            @(negedge clk);
            check("t4_rsp_hold", bus.rsp_result, sr);
            check("t4_alu_a_hold", bus.alu_a, sa);
            check("t4_alu_b_hold", bus.alu_b, sb);
            check("t4_rsp_valid", W'(bus.rsp_valid), 1);
            check("t4_busy", W'(bus.busy), 1);
            check("t4_ready0", W'(bus.req0_ready), 0);
            check("t4_ready1", W'(bus.req1_ready), 0);
        end
        @(posedge clk); #1 bus.rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("t4_idle_busy", W'(bus.busy), 0);
        check("t4_idle_rsp_valid", W'(bus.rsp_valid), 0);
        check("t4_idle_ready0", W'(bus.req0_ready), 1);
        @(posedge clk); #1 bus.req0_valid = 1'b0;
        wait_rsp(lat);
        check("t4_next_latency", lat, S);
        // Reset while the counter is at 2: the operation is dropped
        @(posedge clk); #1;
        bus.req0_valid = 1'b1; bus.req0_cmd = CMD_ADD; bus.req0_a = W'($urandom); bus.req0_b = W'($urandom);
        wait_accept(who);
        @(posedge clk); #1 bus.req0_valid = 1'b0;
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            seen = seen | bus.rsp_valid;
        end
        check("t5_no_rsp", W'(seen), 0);
        check("t5_busy", W'(bus.busy), 0);
        @(posedge clk); #1;
        bus.req1_valid = 1'b1; bus.req1_cmd = CMD_XOR; bus.req1_a = 32'hF0F0_F0F0; bus.req1_b = 32'hFFFF_FFFF;
        wait_accept(who);
        check("t5_grant", who, 1);
        @(posedge clk); #1 bus.req1_valid = 1'b0;
        wait_rsp(lat);
        check("t5_result", bus.rsp_result, 32'h0F0F_0F0F);
        check("t5_id", W'(bus.rsp_id), 1);
        // Signed overflow on ADD
        @(posedge clk); #1;
        bus.req1_valid = 1'b1; bus.req1_cmd = CMD_ADD; bus.req1_a = 32'h7FFF_FFFF; bus.req1_b = 32'h0000_0001;
        wait_accept(who);
        @(posedge clk); #1 bus.req1_valid = 1'b0;
        wait_rsp(lat);
        check("t6_result", bus.rsp_result, 32'h8000_0000);
        check("t6_ovf", W'(bus.rsp_overflow), 1);
        check("t6_carry", W'(bus.rsp_carryout), 0);
        check("t6_zero", W'(bus.rsp_zero), 0);
        check("t6_id", W'(bus.rsp_id), 1);
        // Randomized traffic with random backpressure; the model checks every cycle
        base = n_rsp;
        for (int c = 0; c < 400; c++) begin
            logic a0, a1;
            @(negedge clk);
            a0 = bus.req0_valid && bus.req0_ready;
            a1 = bus.req1_valid && bus.req1_ready;
            @(posedge clk); #1;
            if (!bus.req0_valid || a0) begin
                bus.req0_valid = 1'($urandom_range(0, 1));
                bus.req0_cmd   = 3'($urandom);
                bus.req0_a     = pick();
                bus.req0_b     = pick();
            end
            if (!bus.req1_valid || a1) begin
                bus.req1_valid = 1'($urandom_range(0, 1));
                bus.req1_cmd   = 3'($urandom);
                bus.req1_a     = pick();
                bus.req1_b     = pick();
            end
            bus.rsp_ready = $urandom_range(0, 3) != 0;
        end
        @(negedge clk);
        @(posedge clk); #1;
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0; bus.rsp_ready = 1'b1;
        repeat (20) @(posedge clk);
        @(negedge clk);
        check("rand_rsp_count", W'(n_rsp - base > 15), 1);
        check("rand_drained", W'(bus.busy), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
